bus_region_decoder: RTL and testbench
=====================================

Name: bus_region_decoder

Overview:
- Parametrised, registered successor to the DRAM address decoder for the 68040 local bus.
- Latches the address on each transfer start (nTS) and decodes it against NREG programmable base/mask regions.
- Holds a one-hot region select for the whole transfer and releases it on slave termination (nTA/nTEA).
- Terminates unmapped accesses and hung transfers itself with a generated bus error.

Parameters:
- NREG, 4, number of decoded regions (1..8)
- REGION_BASE, {32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}, packed NREG*32 base addresses; region i in bits [32i+31:32i]
- REGION_MASK, {4{32'hE000_0000}}, packed NREG*32 compare masks; a 1 bit means the address bit is compared
- TIMEOUT, 255, BCLK cycles a selected transfer may stay unterminated before a bus error is generated (1..65535)

Ports:
- BCLK  in  1  bus clock; all state changes on rising edge
- nRESET  in  1  asynchronous active-low reset
- A  in  32  68040 address bus
- nTS  in  1  transfer start, active low, valid for one BCLK
- nTA_in  in  1  slave transfer acknowledge, active low
- nTEA_in  in  1  slave transfer error, active low
- sel  out  NREG  one-hot region select, active high, registered
- busy  out  1  transfer in progress (select held or error being driven)
- nTEA_out  out  1  decoder-generated bus error, active low, registered
- timeout  out  1  sticky flag, set on timeout termination, cleared by the next nTS

Behaviour:
- Reset (nRESET low, asynchronous): state=IDLE; sel=0; busy=0; nTEA_out=1; timeout=0; counter=0.
- Match rule: region i hits when (A & MASK_i) == (BASE_i & MASK_i).
  - Overlapping hits resolve to the lowest index.
  - sel is always one-hot or zero.
- State machine:
  - IDLE:
    - nTS sampled low with a hit: register sel, busy=1, counter=0, timeout=0, go to ACTIVE. sel is valid on the edge after nTS (1-cycle latency).
    - nTS sampled low with no hit: sel stays 0, busy=1, nTEA_out=0, timeout=0, go to ERR.
  - ACTIVE:
    - counter increments each cycle.
    - nTA_in or nTEA_in sampled low: clear sel and busy, go to IDLE.
    - Else if counter == TIMEOUT-1: clear sel, nTEA_out=0, timeout=1, go to ERR.
    - Slave termination on the same edge as the timeout expires wins: no error, timeout stays 0.
  - ERR: nTEA_out low for exactly one BCLK; next edge sets nTEA_out=1, busy=0, go to IDLE.
- nTS asserted while in ACTIVE or ERR: ignored. The 68040 cannot legally start a transfer before termination; no state change.
- Back-to-back: termination in cycle n plus nTS in cycle n+1 gives a new sel in cycle n+2. No dead cycle is needed beyond the IDLE sample.
- Counter width is clog2(TIMEOUT+1) and saturates; it never wraps.
- nRESET asserted mid-transfer: everything returns to reset values immediately; sel drops asynchronously.
- Default parameters make region 0 equal to the existing DRAM window 0x0000_0000–0x1FFF_FFFF.

Test Plan:
- Reset: hold nRESET low with nTS low and A=0 → sel=0000, busy=0, nTEA_out=1, timeout=0 throughout.
- DRAM hit: A=0x1000_0000, nTS low 1 cycle → next edge sel=0001, busy=1. nTA_in low 3 cycles later → sel=0000 and busy=0 on that edge.
- Region priority and coverage:
  - A=0x2000_0004 → sel=0010.
  - A=0x7FFF_FFFC → sel=1000.
  - With REGION_BASE[1]=0 and REGION_MASK[1]=0xF000_0000 overriding, A=0x0000_0010 → sel=0001 (lowest index wins).
- Unmapped: A=0x8000_0000, nTS → next edge sel=0000, nTEA_out low for exactly 1 cycle, then idle, timeout=0.
- Timeout: TIMEOUT=8, A=0x0, no slave response → sel held 8 cycles, then sel=0, nTEA_out low 1 cycle, timeout=1. Next nTS clears timeout.
- Race and reset:
  - nTA_in low on the exact expiry edge → normal termination, nTEA_out stays 1, timeout=0.
  - nRESET pulsed during ACTIVE → sel=0 immediately (asynchronous).

Source files
------------

// File: rtl/bus_region_decoder.sv
// Registered 68040 local-bus region decoder: latches A on nTS, holds a one-hot
// select until nTA/nTEA, and raises its own bus error on unmapped or hung transfers.
module bus_region_decoder #(
    parameter int                 NREG        = 4,
    parameter logic [NREG*32-1:0] REGION_BASE = {32'h6000_0000, 32'h4000_0000,
                                                 32'h2000_0000, 32'h0000_0000},
    parameter logic [NREG*32-1:0] REGION_MASK = {4{32'hE000_0000}},
    parameter int                 TIMEOUT     = 255
) (
    input  logic            BCLK,
    input  logic            nRESET,
    input  logic [31:0]     A,
    input  logic            nTS,
    input  logic            nTA_in,
    input  logic            nTEA_in,
    output logic [NREG-1:0] sel,
    output logic            busy,
    output logic            nTEA_out,
    output logic            timeout
);

    localparam int             CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERR
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [NREG-1:0] hit;

    // Scanning from the top down lets the lowest matching index overwrite the
    // rest, so overlapping regions always yield a single one-hot select.
    always_comb begin
        // NOTE: default first so every path assigns hit and no latch is inferred.
        hit = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((A & REGION_MASK[32*i +: 32]) ==
                (REGION_BASE[32*i +: 32] & REGION_MASK[32*i +: 32])) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge BCLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            sel      <= '0;
            busy     <= 1'b0;
            nTEA_out <= 1'b1;
            timeout  <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!nTS) begin
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        cnt     <= '0;
                        if (|hit) begin
                            sel   <= hit;
                            state <= ACTIVE;
                        end else begin
                            nTEA_out <= 1'b0;
                            state    <= ERR;
                        end
                    end
                end

                ACTIVE: begin
                    // Slave termination is checked first so it beats a
                    // timeout expiring on the same edge.
                    if (!nTA_in || !nTEA_in) begin
                        sel   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == TLAST) begin
                        sel      <= '0;
                        nTEA_out <= 1'b0;
                        timeout  <= 1'b1;
                        state    <= ERR;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ERR: begin
                    nTEA_out <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder: expected outputs are queued as each
// cycle's stimulus is driven and popped for comparison after the clock edge.
module tb_bus_region_decoder;

    logic        BCLK = 1'b0;
    logic        nRESET;
    logic [31:0] A;
    logic        nTS, nTA_in, nTEA_in;

    logic [3:0]  sel_a, sel_b;
    logic        busy_a, busy_b, ntea_a, ntea_b, tmo_a, tmo_b;

    int errors = 0;
    int checks = 0;

    // Default regions, short timeout.
    bus_region_decoder #(.TIMEOUT(8)) u_a (
        .BCLK(BCLK), .nRESET(nRESET), .A(A), .nTS(nTS), .nTA_in(nTA_in),
        .nTEA_in(nTEA_in), .sel(sel_a), .busy(busy_a), .nTEA_out(ntea_a),
        .timeout(tmo_a)
    );

    // Region 1 overlaps region 0 (base 0, mask F000_0000).
    bus_region_decoder #(
        .REGION_BASE({32'h6000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000}),
        .REGION_MASK({32'hE000_0000, 32'hE000_0000, 32'hF000_0000, 32'hE000_0000})
    ) u_b (
        .BCLK(BCLK), .nRESET(nRESET), .A(A), .nTS(nTS), .nTA_in(nTA_in),
        .nTEA_in(nTEA_in), .sel(sel_b), .busy(busy_b), .nTEA_out(ntea_b),
        .timeout(tmo_b)
    );

    always #5 BCLK = ~BCLK;

    typedef struct {
        string      tag;
        logic [6:0] a_vec;   // {sel, busy, nTEA_out, timeout} of u_a
        logic       chk_b;
        logic [3:0] sel_b;
    } exp_t;

    exp_t sb[$];

    function automatic logic [6:0] ev(input logic [3:0] s, input logic b,
                                      input logic n, input logic t);
        return {s, b, n, t};
    endfunction

    task automatic push_exp(input string tag, input logic [6:0] a_vec,
                            input logic chk_b, input logic [3:0] eb);
        exp_t e;
        e.tag   = tag;
        e.a_vec = a_vec;
        e.chk_b = chk_b;
        e.sel_b = eb;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert ({sel_a, busy_a, ntea_a, tmo_a} === e.a_vec) else begin
            errors++;
            $error("FAIL %s {sel,busy,nTEA_out,timeout} observed=%b expected=%b",
                   e.tag, {sel_a, busy_a, ntea_a, tmo_a}, e.a_vec);
        end
        if (e.chk_b) begin
            checks++;
            assert (sel_b === e.sel_b) else begin
                errors++;
                $error("FAIL %s_b sel observed=%b expected=%b", e.tag, sel_b, e.sel_b);
            end
        end
    endtask

    // One bus cycle: drive at negedge, queue expectation, compare 1 ns after posedge.
    task automatic cyc(input logic [31:0] a, input logic nts, input logic nta,
                       input logic ntea_i, input logic [6:0] a_vec, input string tag,
                       input logic chk_b, input logic [3:0] eb);
        @(negedge BCLK);
        A       = a;
        nTS     = nts;
        nTA_in  = nta;
        nTEA_in = ntea_i;
        push_exp(tag, a_vec, chk_b, eb);
        @(posedge BCLK);
        #1;
        compare_head();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRESET  = 1'b0;
        A       = 32'h0;
        nTS     = 1'b0;
        nTA_in  = 1'b1;
        nTEA_in = 1'b1;

        // Reset held with nTS asserted: nothing may start.
        for (int i = 0; i < 3; i++)
            cyc(32'h0, 1'b0, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "reset_hold", 1'b1, 4'b0000);

        @(negedge BCLK);
        nTS    = 1'b1;
        nRESET = 1'b1;
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "post_reset_idle", 1'b1, 4'b0000);

        // Overlap: u_b regions 0 and 1 both hit, lowest index wins.
        cyc(32'h0000_0010, 1'b0, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "overlap_prio", 1'b1, 4'b0001);
        cyc(32'h0, 1'b1, 1'b0, 1'b1, ev(4'b0000, 0, 1, 0), "overlap_term", 1'b1, 4'b0000);

        // DRAM window hit, slave acknowledges three cycles later.
        cyc(32'h1000_0000, 1'b0, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "dram_hit", 1'b1, 4'b0001);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "dram_hold1", 1'b1, 4'b0001);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "dram_hold2", 1'b1, 4'b0001);
        cyc(32'h0, 1'b1, 1'b0, 1'b1, ev(4'b0000, 0, 1, 0), "dram_ta", 1'b1, 4'b0000);

        // Region 1, then back-to-back region 3 with an ignored nTS mid-transfer.
        cyc(32'h2000_0004, 1'b0, 1'b1, 1'b1, ev(4'b0010, 1, 1, 0), "region1_hit", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b0, 1'b1, ev(4'b0000, 0, 1, 0), "region1_ta", 1'b0, 4'b0000);
        cyc(32'h7FFF_FFFC, 1'b0, 1'b1, 1'b1, ev(4'b1000, 1, 1, 0), "b2b_region3", 1'b0, 4'b0000);
        cyc(32'h0, 1'b0, 1'b1, 1'b1, ev(4'b1000, 1, 1, 0), "nts_in_active", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b0, ev(4'b0000, 0, 1, 0), "slave_tea", 1'b0, 4'b0000);

        // Unmapped: one-cycle generated bus error, no timeout flag.
        cyc(32'h8000_0000, 1'b0, 1'b1, 1'b1, ev(4'b0000, 1, 0, 0), "unmapped_err", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "unmapped_release", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "unmapped_idle", 1'b0, 4'b0000);

        // nTS during the error cycle is ignored.
        cyc(32'hA000_0000, 1'b0, 1'b1, 1'b1, ev(4'b0000, 1, 0, 0), "unmapped_err2", 1'b0, 4'b0000);
        cyc(32'h0, 1'b0, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "nts_in_err", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "after_nts_in_err", 1'b0, 4'b0000);

        // Timeout (TIMEOUT=8): sel held for 8 cycles, then a generated error.
        cyc(32'h0, 1'b0, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "to_start", 1'b0, 4'b0000);
        for (int i = 0; i < 7; i++)
            cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "to_hold", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 1, 0, 1), "to_expire", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 1), "to_release", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 1), "to_sticky", 1'b0, 4'b0000);
        cyc(32'h2000_0004, 1'b0, 1'b1, 1'b1, ev(4'b0010, 1, 1, 0), "to_cleared", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b0, 1'b1, ev(4'b0000, 0, 1, 0), "to_cleared_ta", 1'b0, 4'b0000);

        // Race: nTA on the expiry edge terminates normally.
        cyc(32'h0, 1'b0, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "race_start", 1'b0, 4'b0000);
        for (int i = 0; i < 7; i++)
            cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0001, 1, 1, 0), "race_hold", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b0, 1'b1, ev(4'b0000, 0, 1, 0), "race_ta_wins", 1'b0, 4'b0000);
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "race_idle", 1'b0, 4'b0000);

        // Asynchronous reset mid-transfer drops sel before the next edge.
        cyc(32'h4000_0000, 1'b0, 1'b1, 1'b1, ev(4'b0100, 1, 1, 0), "region2_hit", 1'b1, 4'b0100);
        @(negedge BCLK);
        nTS = 1'b1;
        #2;
        nRESET = 1'b0;
        push_exp("async_reset", ev(4'b0000, 0, 1, 0), 1'b1, 4'b0000);
        #1;
        compare_head();
        @(negedge BCLK);
        nRESET = 1'b1;
        cyc(32'h0, 1'b1, 1'b1, 1'b1, ev(4'b0000, 0, 1, 0), "after_async_reset", 1'b1, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
